// File: rtl/sr04_pkg.sv
// Shared constants for the HC-SR04 ranging controller: state encoding,
// echo result width and the saturating increment used by the width counter.
package sr04_pkg;

    localparam int ECHO_W = 16;
    localparam logic [ECHO_W-1:0] ECHO_SAT = 16'hFFFF;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TRIG      = 3'd1;
    localparam logic [2:0] ST_WAIT_RISE = 3'd2;
    localparam logic [2:0] ST_MEAS      = 3'd3;
    localparam logic [2:0] ST_HOLDOFF   = 3'd4;

    function automatic logic [ECHO_W-1:0] sat_inc(input logic [ECHO_W-1:0] v);
        return (v == ECHO_SAT) ? v : v + ECHO_W'(1);
    endfunction

endpackage

// File: rtl/sr04_ranger_if.sv
// Control/result handshake plus the s1 sensor pins of the ranging controller.
interface sr04_ranger_if;
    import sr04_pkg::*;

    logic              start;
    logic              cont;
    logic              s1_trig;
    logic              s1_echo;
    logic              busy;
    logic              done;
    logic [ECHO_W-1:0] echo_us;
    logic              timeout;

    modport slave (
        input  start, cont, s1_echo,
        output s1_trig, busy, done, echo_us, timeout
    );

    modport master (
        output start, cont, s1_echo,
        input  s1_trig, busy, done, echo_us, timeout
    );

endinterface

// File: rtl/sr04_us_tick.sv
// Microsecond prescaler: counts 0..TICK_DIV-1, tick on terminal count,
// synchronous clear restarts the count so a timer can start aligned.
module sr04_us_tick #(
    parameter int TICK_DIV = 50
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == TERM);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sr04_ranger.sv
// HC-SR04 controller: drives the trigger pulse, times the synchronized echo
// in microseconds and reports the width (or a timeout) with a done pulse.
module sr04_ranger
    import sr04_pkg::*;
#(
    parameter int TICK_DIV   = 50,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int PERIOD_US  = 60000
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    sr04_ranger_if.slave  bus
);
    localparam int TRIG_CYC = TRIG_US * TICK_DIV;
    localparam int TCW = $clog2(TRIG_CYC + 1);
    localparam int PW  = $clog2(PERIOD_US + 1);
    localparam int TW  = $clog2(TIMEOUT_US + 1);
    localparam logic [TCW-1:0] TRIG_LAST   = TCW'(TRIG_CYC - 1);
    localparam logic [PW-1:0]  PERIOD_END  = PW'(PERIOD_US);
    localparam logic [TW-1:0]  TIMEOUT_END = TW'(TIMEOUT_US);

    logic [2:0]        state, state_nxt;
    logic [2:0]        echo_sync;
    logic              echo_rise, echo_fall;
    logic              tick, ptick;
    logic              xfer, trig_entry, meas_entry;
    logic              to_hit, period_done, timing;
    logic [TCW-1:0]    trig_cnt;
    logic [PW-1:0]     period_cnt;
    logic [TW-1:0]     timeout_cnt;
    logic [ECHO_W-1:0] width_cnt;
    logic [ECHO_W-1:0] echo_us_q;
    logic              s1_trig_q, done_q, timeout_q;

    // [0] metastable stage, [1] synchronized echo, [2] previous synchronized value
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) echo_sync <= '0;
        else        echo_sync <= {echo_sync[1:0], bus.s1_echo};
    end

    assign echo_rise = echo_sync[1] & ~echo_sync[2];
    assign echo_fall = ~echo_sync[1] & echo_sync[2];

    assign timing      = (state == ST_WAIT_RISE) || (state == ST_MEAS);
    assign to_hit      = (timeout_cnt == TIMEOUT_END);
    assign period_done = (period_cnt == PERIOD_END);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (bus.start || bus.cont) state_nxt = ST_TRIG;
            ST_TRIG:      if (trig_cnt == TRIG_LAST) state_nxt = ST_WAIT_RISE;
            ST_WAIT_RISE: begin
                if (to_hit)         state_nxt = ST_HOLDOFF;
                else if (echo_rise) state_nxt = ST_MEAS;
            end
            ST_MEAS:      if (echo_fall || to_hit) state_nxt = ST_HOLDOFF;
            ST_HOLDOFF:   if (period_done) state_nxt = bus.cont ? ST_TRIG : ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    assign xfer       = (state_nxt != state);
    assign trig_entry = xfer && (state_nxt == ST_TRIG);
    assign meas_entry = xfer && (state_nxt == ST_MEAS);

    // Width timer restarts on every state change; period/timeout share a
    // prescaler aligned to trigger rise, which TRIG exit also lands on.
    sr04_us_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .clr     (xfer),
        .tick    (tick)
    );

    sr04_us_tick #(.TICK_DIV(TICK_DIV)) u_ptick (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .clr     (trig_entry),
        .tick    (ptick)
    );

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            s1_trig_q   <= 1'b0;
            trig_cnt    <= '0;
            period_cnt  <= '0;
            timeout_cnt <= '0;
            width_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            s1_trig_q <= (state_nxt == ST_TRIG);

            if (trig_entry)             trig_cnt <= '0;
            else if (state == ST_TRIG)  trig_cnt <= trig_cnt + TCW'(1);

            if (trig_entry)                  period_cnt <= '0;
            else if (ptick && !period_done)  period_cnt <= period_cnt + PW'(1);

            if (state == ST_TRIG)                  timeout_cnt <= '0;
            else if (timing && ptick && !to_hit)   timeout_cnt <= timeout_cnt + TW'(1);

            if (meas_entry)                    width_cnt <= '0;
            else if (state == ST_MEAS && tick) width_cnt <= sat_inc(width_cnt);
        end
    end

    // A falling edge beats a coincident timeout; the tick in the exit cycle
    // is folded into the captured width.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            echo_us_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (state == ST_MEAS && echo_fall) begin
                echo_us_q <= tick ? sat_inc(width_cnt) : width_cnt;
                timeout_q <= 1'b0;
                done_q    <= 1'b1;
            end else if (timing && to_hit) begin
                echo_us_q <= ECHO_SAT;
                timeout_q <= 1'b1;
                done_q    <= 1'b1;
            end
        end
    end

    assign bus.s1_trig = s1_trig_q;
    assign bus.busy    = (state != ST_IDLE);
    assign bus.done    = done_q;
    assign bus.echo_us = echo_us_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_sr04_ranger.sv
// Bench for sr04_ranger: sensor model on s1, table of measurement scenarios,
// continuous and reset sequences, and randomized echoes against a rule model.
module tb_sr04_ranger;
    import sr04_pkg::*;

    localparam int TD      = 5;
    localparam int TRIG_US = 10;
    localparam int TO_US   = 250;
    localparam int PER_US  = 400;
    localparam int M_ECHO  = 0;
    localparam int M_QUIET = 1;

    typedef struct {
        int mode;
        int w_us;
        int d_us;
        bit extra;
        bit stuck;
        bit exp_to;
        int lo;
        int hi;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic echo_pulse = 1'b0;
    logic echo_stuck = 1'b0;
    logic trig_q = 1'b0;
    logic busy_q = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int sens_mode = M_QUIET;
    int sens_w = 0;
    int sens_d = 0;
    int n_done = 0;
    int trig_rise_cyc = 0;
    int trig_fall_cyc = 0;
    int trig_len = 0;
    int done_cyc = 0;
    int busy_fall_cyc = 0;
    int d_echo = 0;
    int d_to = 0;
    int rise_q[$];

    vec_t vecs [7];

    sr04_ranger_if bus ();
    assign bus.s1_echo = echo_pulse | echo_stuck;

    sr04_ranger #(
        .TICK_DIV   (TD),
        .TRIG_US    (TRIG_US),
        .TIMEOUT_US (TO_US),
        .PERIOD_US  (PER_US)
    ) dut (
        .clk_sys (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.s1_trig && !trig_q) begin
            rise_q.push_back(cyc);
            trig_rise_cyc = cyc;
        end
        if (!bus.s1_trig && trig_q) begin
            trig_fall_cyc = cyc;
            trig_len = cyc - trig_rise_cyc;
        end
        trig_q = bus.s1_trig;
        if (bus.done) begin
            n_done++;
            done_cyc = cyc;
            d_echo = int'(bus.echo_us);
            d_to = int'(bus.timeout);
        end
        if (!bus.busy && busy_q) busy_fall_cyc = cyc;
        busy_q = bus.busy;
    end

    // Sensor: echo starts sens_d cycles after trigger fall, lasts sens_w us.
    always begin
        @(negedge bus.s1_trig);
        if (rst_n && sens_mode == M_ECHO) begin
            repeat (sens_d) @(negedge clk);
            echo_pulse = 1'b1;
            repeat (sens_w * TD) @(negedge clk);
            echo_pulse = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int nd0, input int lim, input string name);
        int k = 0;
        while (n_done <= nd0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (n_done <= nd0) check({name, " done timeout"}, 0, 1, 1);
    endtask

    task automatic wait_rise(input int nr0, input int lim, input string name);
        int k = 0;
        while (rise_q.size() <= nr0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (rise_q.size() <= nr0) check({name, " trig timeout"}, 0, 1, 1);
    endtask

    task automatic wait_idle(input int lim, input string name);
        int k = 0;
        while (bus.busy && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (bus.busy) check({name, " idle timeout"}, 1, 0, 0);
        @(negedge clk);
    endtask

    task automatic measure(input string nm, input vec_t v);
        int nd0;
        int nr0;
        sens_mode = v.mode;
        sens_w = v.w_us;
        sens_d = v.d_us * TD;
        echo_stuck = v.stuck;
        nd0 = n_done;
        nr0 = rise_q.size();
        pulse_start();
        if (v.extra) begin
            repeat ((TRIG_US + v.d_us + v.w_us / 2) * TD) @(negedge clk);
            pulse_start();
            wait_done(nd0, (TO_US + 20) * TD, nm);
            repeat (10) @(negedge clk);
            pulse_start();
        end
        wait_idle((PER_US + 20) * TD, nm);
        echo_stuck = 1'b0;
        check({nm, " trig_width"}, trig_len, TRIG_US * TD, TRIG_US * TD);
        check({nm, " trig_count"}, rise_q.size() - nr0, 1, 1);
        check({nm, " done_count"}, n_done - nd0, 1, 1);
        check({nm, " echo_us"}, d_echo, v.lo, v.hi);
        check({nm, " timeout"}, d_to, int'(v.exp_to), int'(v.exp_to));
        check({nm, " period"}, busy_fall_cyc - trig_rise_cyc, PER_US * TD, PER_US * TD + 3);
        if (v.exp_to)
            check({nm, " to_latency"}, done_cyc - trig_fall_cyc, TO_US * TD, TO_US * TD + 3);
        check({nm, " echo_hold"}, int'(bus.echo_us), v.lo, v.hi);
    endtask

    initial begin
        int nd0;
        int nr0;
        int w;
        int d;
        vec_t rv;

        bus.start = 1'b0;
        bus.cont  = 1'b0;

        vecs[0] = '{M_ECHO,  58,  20, 1'b0, 1'b0, 1'b0, 57, 59};
        vecs[1] = '{M_QUIET,  0,   0, 1'b0, 1'b0, 1'b1, 65535, 65535};
        vecs[2] = '{M_QUIET,  0,   0, 1'b0, 1'b1, 1'b1, 65535, 65535};
        vecs[3] = '{M_ECHO, 116,  50, 1'b1, 1'b0, 1'b0, 115, 117};
        vecs[4] = '{M_ECHO, 200,  40, 1'b0, 1'b0, 1'b0, 199, 201};
        vecs[5] = '{M_ECHO, 120, 140, 1'b0, 1'b0, 1'b1, 65535, 65535};
        vecs[6] = '{M_ECHO,  50, 260, 1'b0, 1'b0, 1'b1, 65535, 65535};

        repeat (3) @(negedge clk);
        check("reset s1_trig", int'(bus.s1_trig), 0, 0);
        check("reset busy", int'(bus.busy), 0, 0);
        check("reset done", int'(bus.done), 0, 0);
        check("reset echo_us", int'(bus.echo_us), 0, 0);
        check("reset timeout", int'(bus.timeout), 0, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 7; i++) measure($sformatf("vec%0d", i), vecs[i]);

        // continuous mode, cont dropped during the fourth trigger
        sens_mode = M_ECHO;
        sens_w = 116;
        sens_d = 20 * TD;
        nd0 = n_done;
        nr0 = rise_q.size();
        @(negedge clk);
        bus.cont = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_done(nd0 + k, (PER_US + 20) * TD, "cont");
            check($sformatf("cont%0d echo_us", k), d_echo, 115, 117);
            check($sformatf("cont%0d timeout", k), d_to, 0, 0);
        end
        wait_rise(nr0 + 3, (PER_US + 20) * TD, "cont");
        repeat (5) @(negedge clk);
        bus.cont = 1'b0;
        wait_idle((PER_US + 20) * TD, "cont");
        check("cont done_count", n_done - nd0, 4, 4);
        check("cont last echo_us", d_echo, 115, 117);
        repeat (50 * TD) @(negedge clk);
        check("cont trig_count", rise_q.size() - nr0, 4, 4);
        for (int k = 0; k < 3; k++)
            if (rise_q.size() >= nr0 + k + 2)
                check($sformatf("cont interval%0d", k), rise_q[nr0 + k + 1] - rise_q[nr0 + k],
                      PER_US * TD, PER_US * TD + 3);

        // reset during the trigger pulse
        nd0 = n_done;
        pulse_start();
        repeat (20) @(negedge clk);
        check("pre-reset trig", int'(bus.s1_trig), 1, 1);
        rst_n = 1'b0;
        #1;
        check("rst-trig s1_trig", int'(bus.s1_trig), 0, 0);
        check("rst-trig busy", int'(bus.busy), 0, 0);
        check("rst-trig echo_us", int'(bus.echo_us), 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20 * TD) @(negedge clk);
        check("rst-trig no_done", n_done - nd0, 0, 0);

        // reset while the echo is being measured
        pulse_start();
        repeat ((TRIG_US + 20 + 60) * TD) @(negedge clk);
        check("pre-reset meas busy", int'(bus.busy), 1, 1);
        rst_n = 1'b0;
        #1;
        check("rst-meas busy", int'(bus.busy), 0, 0);
        check("rst-meas s1_trig", int'(bus.s1_trig), 0, 0);
        check("rst-meas echo_us", int'(bus.echo_us), 0, 0);
        check("rst-meas timeout", int'(bus.timeout), 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (120 * TD) @(negedge clk);
        check("rst-meas no_done", n_done - nd0, 0, 0);
        check("rst-meas idle", int'(bus.busy), 0, 0);
        measure("post-reset", vecs[0]);

        // randomized echoes: width is reported when the echo ends inside the window
        for (int r = 0; r < 6; r++) begin
            w = int'($urandom_range(220, 10));
            d = int'($urandom_range(120, 1));
            while (d + w > TO_US - 4 && d + w < TO_US + 4) d = int'($urandom_range(120, 1));
            rv.mode   = M_ECHO;
            rv.w_us   = w;
            rv.d_us   = d;
            rv.stuck  = 1'b0;
            rv.exp_to = (d + w > TO_US);
            rv.extra  = !rv.exp_to && ($urandom_range(1, 0) == 1);
            rv.lo     = rv.exp_to ? 65535 : w - 1;
            rv.hi     = rv.exp_to ? 65535 : w + 1;
            measure($sformatf("rand%0d w=%0d d=%0d", r, w, d), rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sr04_ranger.md
Name: sr04_ranger

Overview:
- Design-side controller for the HC-SR04 ultrasonic sensor on the s1 sensor interface: drives s1_trig, times the s1_echo pulse, and reports the echo width in microseconds.
- Opposite end of the sensor behavioural model used on the bench.
- Sits inside the sensor subsystem of top; its result feeds the uart reporting path.
- Supports single-shot and continuous ranging, with a timeout for a missing or overlong echo.

Parameters:
- TICK_DIV, 50, clk_sys cycles per microsecond (50 MHz mclk0).
- TRIG_US, 10, trigger pulse width in microseconds.
- TIMEOUT_US, 30000, maximum time from trigger fall to echo fall before declaring timeout.
- PERIOD_US, 60000, minimum time from one trigger rise to the next.

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request for a measurement; ignored while busy.
- cont  in  1  continuous mode: re-trigger automatically after each period.
- s1_trig  out  1  trigger to sensor.
- s1_echo  in  1  echo from sensor (asynchronous).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when echo_us and timeout are updated.
- echo_us  out  16  last echo width in microseconds; 16'hFFFF on timeout.
- timeout  out  1  1 when the last measurement timed out.

Behaviour:
- Reset values: s1_trig=0, busy=0, done=0, echo_us=0, timeout=0, state IDLE, all counters 0.
- Reset mid-operation: s1_trig drops asynchronously and no done pulse is issued.
- s1_echo passes through a 2-FF synchronizer, then a rising/falling edge detector on the synchronized value. This adds 2-3 cycles of latency, equal on both edges.
- us tick: prescaler counts 0..TICK_DIV-1 and asserts tick on terminal count. It is cleared on every state transition so state timers start aligned.
- PERIOD timer counts ticks from TRIG entry and saturates at PERIOD_US.
- IDLE:
  - (start or cont)=1 -> TRIG.
- TRIG:
  - s1_trig=1 for exactly TRIG_US*TICK_DIV clk_sys cycles (500 at defaults).
  - Then -> WAIT_RISE; timeout counter cleared.
- WAIT_RISE:
  - Synchronized rising edge -> MEAS; width counter cleared.
  - An echo already high on entry does not count; a fresh rising edge is required.
- MEAS:
  - Width counter increments per tick and saturates at 16'hFFFF.
  - Falling edge -> echo_us=width, timeout=0, done=1 for one cycle -> HOLDOFF.
- Timeout:
  - The timeout counter runs across WAIT_RISE and MEAS.
  - Reaching TIMEOUT_US -> echo_us=16'hFFFF, timeout=1, done=1 -> HOLDOFF.
  - If the falling edge and timeout occur in the same cycle, the falling edge wins.
- HOLDOFF:
  - Wait until the PERIOD timer reaches PERIOD_US.
  - Then cont=1 -> TRIG, otherwise -> IDLE. cont is sampled only at this transition.
- start pulses in any state other than IDLE are dropped; they are not queued.
- Quantization: echo_us is within ±1 of the true width in µs.
- echo_us and timeout hold their values until the next done.

Decomposition:
- Package sr04_pkg:
  - State enum (IDLE, TRIG, WAIT_RISE, MEAS, HOLDOFF).
  - ECHO_W=16.
  - Saturation constant ECHO_SAT=16'hFFFF.
- One sub-module, sr04_us_tick: a prescaler with a synchronous clear input and a tick output.

Test Plan:
All scenarios use defaults (TICK_DIV=50).
1. start pulse, sensor model echo 580 us -> s1_trig high exactly 500 cycles; one done; echo_us in 579..581; timeout=0; busy drops 60000 us after trig rise.
2. start, echo never rises -> done 30000 us after trig fall; echo_us=16'hFFFF; timeout=1.
3. Echo stuck high from before trigger, never falls -> no MEAS entry from a stale level; timeout=1 after 30000 us.
4. cont=1, echo 1160 us -> trig rises every 60000 us; echo_us 1159..1161 each time. Clear cont mid-run -> exactly one more measurement, then IDLE.
5. Extra start pulses during MEAS and HOLDOFF -> ignored; exactly one done per trigger.
6. rst_n asserted while s1_trig=1, and again in MEAS -> s1_trig=0 and busy=0 immediately; no done; echo_us=0. A new start after reset behaves as in scenario 1.
